// File: rtl/mm_if.sv
// Memory-bus bundle between the mm stage (master) and the data memory (slave).
interface mm_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byte_en, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mm.sv
// Memory stage: passes R2R results through, runs aligned loads/stores on the bus with
// a timeout, formats load data (incl. LWL/LWR merges) and reports address/bus errors.
module mm #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  mem_access_type,
  input  logic [2:0]  mem_access_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_access_addr,
  input  logic [31:0] val_input,
  input  logic [4:0]  bypass_reg_addr,
  mm_if.master        bus,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] val_output,
  output logic [4:0]  reg_addr_out,
  output logic        address_error,
  output logic        bus_error,
  output logic [31:0] bad_vaddr
);
  localparam int CW = $clog2(BUS_TIMEOUT + 2);

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_LEFT  = 3'd3;
  localparam logic [2:0] SZ_RIGHT = 3'd4;
  localparam logic [1:0] T_LOAD   = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cap_load_reg, cap_load_next;
  logic [2:0]    cap_size_reg, cap_size_next;
  logic          cap_signed_reg, cap_signed_next;
  logic [31:0]   cap_addr_reg, cap_addr_next;
  logic [31:0]   cap_val_reg, cap_val_next;
  logic [4:0]    cap_rd_reg, cap_rd_next;
  logic          bus_req_reg, bus_req_next;
  logic          bus_we_reg, bus_we_next;
  logic [31:0]   bus_addr_reg, bus_addr_next;
  logic [3:0]    bus_be_reg, bus_be_next;
  logic [31:0]   bus_wdata_reg, bus_wdata_next;
  logic          out_valid_reg, out_valid_next;
  logic [31:0]   val_output_reg, val_output_next;
  logic [4:0]    reg_addr_reg, reg_addr_next;
  logic          aerr_reg, aerr_next;
  logic          berr_reg, berr_next;
  logic [31:0]   bad_vaddr_reg, bad_vaddr_next;

  // Decode of the incoming instruction (only meaningful in IDLE)
  logic        is_load, is_store, misaligned;
  logic [1:0]  k_in;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    is_load  = (mem_access_type == T_LOAD);
    is_store = (mem_access_type == T_STORE);
    k_in     = mem_access_addr[1:0];
    case (mem_access_size)
      SZ_BYTE, SZ_LEFT, SZ_RIGHT: misaligned = 1'b0;
      SZ_HALF:                    misaligned = k_in[0];
      default:                    misaligned = (k_in != 2'b00);
    endcase
    st_data = val_input << {k_in, 3'b000};
    case (mem_access_size)
      SZ_BYTE:  st_be = 4'b0001 << k_in;
      SZ_HALF:  st_be = 4'b0011 << k_in;
      SZ_LEFT: begin
        // 3-k == ~k for a 2-bit lane index
        st_be   = 4'b1111 >> ~k_in;
        st_data = val_input >> {~k_in, 3'b000};
      end
      SZ_RIGHT: st_be = 4'b1111 << k_in;
      default: begin
        st_be   = 4'hF;
        st_data = val_input;
      end
    endcase
  end

  // Load formatting from the returned word and the captured request
  logic [7:0]  m_byte [4];
  logic [1:0]  k_cap;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data, m_w, r_w;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign m_byte[gi] = bus.bus_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    m_w     = bus.bus_rdata;
    r_w     = cap_val_reg;
    k_cap   = cap_addr_reg[1:0];
    ld_b    = m_byte[k_cap];
    ld_h    = {m_byte[{k_cap[1], 1'b1}], m_byte[{k_cap[1], 1'b0}]};
    ld_data = m_w;
    case (cap_size_reg)
      SZ_BYTE: ld_data = cap_signed_reg ? {{24{ld_b[7]}}, ld_b} : {24'd0, ld_b};
      SZ_HALF: ld_data = cap_signed_reg ? {{16{ld_h[15]}}, ld_h} : {16'd0, ld_h};
      SZ_LEFT: begin
        case (k_cap)
          2'd0: ld_data = {m_w[7:0],  r_w[23:0]};
          2'd1: ld_data = {m_w[15:0], r_w[15:0]};
          2'd2: ld_data = {m_w[23:0], r_w[7:0]};
          default: ld_data = m_w;
        endcase
      end
      SZ_RIGHT: begin
        case (k_cap)
          2'd1: ld_data = {r_w[31:24], m_w[31:8]};
          2'd2: ld_data = {r_w[31:16], m_w[31:16]};
          2'd3: ld_data = {r_w[31:8],  m_w[31:24]};
          default: ld_data = m_w;
        endcase
      end
      default: ld_data = m_w;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    cap_load_next   = cap_load_reg;
    cap_size_next   = cap_size_reg;
    cap_signed_next = cap_signed_reg;
    cap_addr_next   = cap_addr_reg;
    cap_val_next    = cap_val_reg;
    cap_rd_next     = cap_rd_reg;
    bus_req_next    = bus_req_reg;
    bus_we_next     = bus_we_reg;
    bus_addr_next   = bus_addr_reg;
    bus_be_next     = bus_be_reg;
    bus_wdata_next  = bus_wdata_reg;
    out_valid_next  = 1'b0;
    val_output_next = val_output_reg;
    reg_addr_next   = reg_addr_reg;
    aerr_next       = 1'b0;
    berr_next       = 1'b0;
    bad_vaddr_next  = bad_vaddr_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (!(is_load || is_store)) begin
            out_valid_next  = 1'b1;
            val_output_next = val_input;
            reg_addr_next   = bypass_reg_addr;
          end else if (misaligned) begin
            out_valid_next = 1'b1;
            aerr_next      = 1'b1;
            bad_vaddr_next = mem_access_addr;
            reg_addr_next  = 5'd0;
          end else begin
            state_next      = ACCESS;
            cnt_next        = '0;
            cap_load_next   = is_load;
            cap_size_next   = mem_access_size;
            cap_signed_next = mem_signed;
            cap_addr_next   = mem_access_addr;
            cap_val_next    = val_input;
            cap_rd_next     = bypass_reg_addr;
            bus_req_next    = 1'b1;
            bus_we_next     = is_store;
            bus_addr_next   = {mem_access_addr[31:2], 2'b00};
            bus_be_next     = is_store ? st_be : 4'hF;
            bus_wdata_next  = is_store ? st_data : 32'd0;
          end
        end
      end
      ACCESS: begin
        if (bus.bus_ack || cnt_reg == CW'(BUS_TIMEOUT)) begin
          state_next     = IDLE;
          bus_req_next   = 1'b0;
          bus_we_next    = 1'b0;
          bus_addr_next  = 32'd0;
          bus_be_next    = 4'd0;
          bus_wdata_next = 32'd0;
          out_valid_next = 1'b1;
          // A late ack still completes the access rather than faulting
          if (bus.bus_ack) begin
            val_output_next = cap_load_reg ? ld_data : 32'd0;
            reg_addr_next   = cap_load_reg ? cap_rd_reg : 5'd0;
          end else begin
            berr_next      = 1'b1;
            bad_vaddr_next = cap_addr_reg;
            reg_addr_next  = 5'd0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cap_load_reg   <= 1'b0;
      cap_size_reg   <= 3'd0;
      cap_signed_reg <= 1'b0;
      cap_addr_reg   <= 32'd0;
      cap_val_reg    <= 32'd0;
      cap_rd_reg     <= 5'd0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= 32'd0;
      bus_be_reg     <= 4'd0;
      bus_wdata_reg  <= 32'd0;
      out_valid_reg  <= 1'b0;
      val_output_reg <= 32'd0;
      reg_addr_reg   <= 5'd0;
      aerr_reg       <= 1'b0;
      berr_reg       <= 1'b0;
      bad_vaddr_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cap_load_reg   <= cap_load_next;
      cap_size_reg   <= cap_size_next;
      cap_signed_reg <= cap_signed_next;
      cap_addr_reg   <= cap_addr_next;
      cap_val_reg    <= cap_val_next;
      cap_rd_reg     <= cap_rd_next;
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_addr_reg   <= bus_addr_next;
      bus_be_reg     <= bus_be_next;
      bus_wdata_reg  <= bus_wdata_next;
      out_valid_reg  <= out_valid_next;
      val_output_reg <= val_output_next;
      reg_addr_reg   <= reg_addr_next;
      aerr_reg       <= aerr_next;
      berr_reg       <= berr_next;
      bad_vaddr_reg  <= bad_vaddr_next;
    end
  end

  assign stall           = (state_reg == ACCESS);
  assign bus.bus_req     = bus_req_reg;
  assign bus.bus_we      = bus_we_reg;
  assign bus.bus_addr    = bus_addr_reg;
  assign bus.bus_byte_en = bus_be_reg;
  assign bus.bus_wdata   = bus_wdata_reg;
  assign out_valid       = out_valid_reg;
  assign val_output      = val_output_reg;
  assign reg_addr_out    = reg_addr_reg;
  assign address_error   = aerr_reg;
  assign bus_error       = berr_reg;
  assign bad_vaddr       = bad_vaddr_reg;
endmodule

// File: tb/tb_mm.sv
// Randomized scoreboard bench for mm: a byte-level reference model predicts writeback
// results and bus lanes; a monitor compares every out_valid against the expected queue.
module tb_mm;
  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mem_access_type;
  logic [2:0]  mem_access_size;
  logic        mem_signed;
  logic [31:0] mem_access_addr;
  logic [31:0] val_input;
  logic [4:0]  bypass_reg_addr;
  logic        stall;
  logic        out_valid;
  logic [31:0] val_output;
  logic [4:0]  reg_addr_out;
  logic        address_error;
  logic        bus_error;
  logic [31:0] bad_vaddr;

  mm_if bif();

  mm #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mem_access_type(mem_access_type), .mem_access_size(mem_access_size),
    .mem_signed(mem_signed), .mem_access_addr(mem_access_addr),
    .val_input(val_input), .bypass_reg_addr(bypass_reg_addr), .bus(bif),
    .stall(stall), .out_valid(out_valid), .val_output(val_output),
    .reg_addr_out(reg_addr_out), .address_error(address_error),
    .bus_error(bus_error), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  rd;
    logic        aerr;
    logic        berr;
    logic [31:0] bad;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_val;
  logic [31:0] model_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] size, input logic sgn,
                                             input logic [1:0] k, input logic [31:0] m,
                                             input logic [31:0] r);
    logic [7:0] mb [4];
    logic [7:0] res [4];
    int ki;
    ki = int'(k);
    for (int i = 0; i < 4; i++) begin
      mb[i]  = m[8*i +: 8];
      res[i] = r[8*i +: 8];
    end
    case (size)
      3'd0: return sgn ? {{24{mb[ki][7]}}, mb[ki]} : {24'd0, mb[ki]};
      3'd1: return sgn ? {{16{mb[ki+1][7]}}, mb[ki+1], mb[ki]} : {16'd0, mb[ki+1], mb[ki]};
      3'd3: begin
        for (int j = 0; j <= ki; j++) res[3-j] = mb[ki-j];
        return {res[3], res[2], res[1], res[0]};
      end
      3'd4: begin
        for (int j = ki; j < 4; j++) res[j-ki] = mb[j];
        return {res[3], res[2], res[1], res[0]};
      end
      default: return m;
    endcase
  endfunction

  task automatic store_model(input logic [2:0] size, input logic [1:0] k, input logic [31:0] v,
                             output logic [3:0] be, output logic [31:0] wd);
    int ki;
    ki = int'(k);
    be = 4'd0;
    wd = v << (8*ki);
    case (size)
      3'd0: be[ki] = 1'b1;
      3'd1: begin be[ki] = 1'b1; be[ki+1] = 1'b1; end
      3'd3: begin
        for (int i = 0; i <= ki; i++) be[i] = 1'b1;
        wd = v >> (8*(3-ki));
      end
      3'd4: for (int i = ki; i < 4; i++) be[i] = 1'b1;
      default: begin be = 4'hF; wd = v; end
    endcase
  endtask

  // lat = ACCESS cycle (1-based) in which ack is driven; lat > TO+1 means never acked
  task automatic issue(input logic [1:0] typ, input logic [2:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] v, input logic [4:0] rd,
                       input int lat, input logic [31:0] m);
    exp_t        e;
    logic        mem, mis, load;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    int          cycles, exp_cycles;
    load = (typ == 2'd1);
    mem  = (typ == 2'd1) || (typ == 2'd2);
    if (size == 3'd1)                                   mis = addr[0];
    else if (size == 3'd0 || size == 3'd3 || size == 3'd4) mis = 1'b0;
    else                                                mis = (addr[1:0] != 2'b00);

    in_valid = 1'b1; mem_access_type = typ; mem_access_size = size; mem_signed = sgn;
    mem_access_addr = addr; val_input = v; bypass_reg_addr = rd;

    e.aerr = 1'b0; e.berr = 1'b0; e.rd = 5'd0;
    if (!mem) begin
      model_val = v; e.rd = rd;
    end else if (mis) begin
      model_bad = addr; e.aerr = 1'b1;
    end else if (lat > TO + 1) begin
      model_bad = addr; e.berr = 1'b1;
    end else if (load) begin
      model_val = load_model(size, sgn, addr[1:0], m, v); e.rd = rd;
    end else begin
      model_val = 32'd0;
    end
    e.val = model_val;
    e.bad = model_bad;
    exp_q.push_back(e);
    $display("txn type=%0d size=%0d sgn=%0d addr=%h val=%h rd=%0d lat=%0d rdata=%h",
             typ, size, sgn, addr, v, rd, lat, m);

    @(negedge clk);
    in_valid = 1'b0;
    if (!mem || mis) begin
      chk("no_stall", {31'd0, stall}, 32'd0);
      chk("no_bus_req", {31'd0, bif.bus_req}, 32'd0);
    end else begin
      if (load) begin ebe = 4'hF; ewd = 32'd0; end
      else store_model(size, addr[1:0], v, ebe, ewd);
      chk("bus_addr", bif.bus_addr, {addr[31:2], 2'b00});
      chk("bus_we", {31'd0, bif.bus_we}, {31'd0, !load});
      chk("bus_byte_en", {28'd0, bif.bus_byte_en}, {28'd0, ebe});
      chk("bus_wdata", bif.bus_wdata, ewd);
      exp_cycles = (lat > TO + 1) ? TO + 1 : lat;
      cycles = 0;
      while (stall && cycles < TO + 4) begin
        cycles++;
        chk("bus_req_held", {31'd0, bif.bus_req}, 32'd1);
        if (cycles == lat) begin
          bif.bus_ack = 1'b1; bif.bus_rdata = m;
        end
        @(negedge clk);
        bif.bus_ack = 1'b0; bif.bus_rdata = $urandom;
      end
      chk("stall_cycles", cycles, exp_cycles);
      chk("bus_req_drop", {31'd0, bif.bus_req}, 32'd0);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("val_output", val_output, e.val);
          chk("reg_addr_out", {27'd0, reg_addr_out}, {27'd0, e.rd});
          chk("address_error", {31'd0, address_error}, {31'd0, e.aerr});
          chk("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
          chk("bad_vaddr", bad_vaddr, e.bad);
        end
      end else begin
        chk("idle_pulses", {30'd0, address_error, bus_error}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  typ;
    logic [2:0]  size;
    int          lat;
    rst_n = 1'b0; in_valid = 1'b0; mem_access_type = 2'd0; mem_access_size = 3'd0;
    mem_signed = 1'b0; mem_access_addr = 32'd0; val_input = 32'd0; bypass_reg_addr = 5'd0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    model_val = 32'd0; model_bad = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_val_output", val_output, 32'd0);
    chk("rst_bad_vaddr", bad_vaddr, 32'd0);
    chk("rst_stall_req", {30'd0, stall, bif.bus_req}, 32'd0);
    chk("rst_errors", {27'd0, reg_addr_out, 1'b0} | {30'd0, address_error, bus_error}, 32'd0);
    rst_n = 1'b1;

    issue(2'd0, 3'd2, 1'b0, 32'h0000_0000, 32'h1234_5678, 5'd5, 0, 32'd0);
    issue(2'd1, 3'd0, 1'b1, 32'h0000_1003, 32'h0, 5'd9, 3, 32'h80FF_0000);
    issue(2'd2, 3'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 1, 32'd0);
    issue(2'd1, 3'd3, 1'b0, 32'h0000_0101, 32'h1122_3344, 5'd7, 2, 32'hAABB_CCDD);
    issue(2'd1, 3'd4, 1'b0, 32'h0000_0102, 32'h1122_3344, 5'd8, 1, 32'hAABB_CCDD);
    issue(2'd1, 3'd2, 1'b0, 32'h0000_0006, 32'h0, 5'd4, 1, 32'd0);
    issue(2'd3, 3'd1, 1'b0, 32'h0000_0003, 32'hCAFE_F00D, 5'd12, 0, 32'd0);
    issue(2'd1, 3'd2, 1'b0, 32'h0000_0040, 32'h0, 5'd6, TO + 2, 32'h5555_AAAA);
    issue(2'd1, 3'd2, 1'b0, 32'h0000_0044, 32'h0, 5'd6, TO + 1, 32'h5555_AAAA);
    issue(2'd2, 3'd3, 1'b0, 32'h0000_0081, 32'hDEAD_BEEF, 5'd1, 1, 32'd0);

    // Reset while an access is outstanding: abandoned, no writeback
    repeat (2) @(negedge clk);
    in_valid = 1'b1; mem_access_type = 2'd1; mem_access_size = 3'd2; mem_access_addr = 32'h100;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    model_val = 32'd0; model_bad = 32'd0;
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      typ  = 2'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 7));
      lat  = $urandom_range(1, TO + 2);
      issue(typ, size, 1'($urandom), $urandom, $urandom, 5'($urandom), lat, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mm.md
MM -- requirements
Module: mm

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255: max cycles in ACCESS awaiting bus_ack before bus_error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  ex result valid this cycle.
REQ-005 mem_access_type  input  2  0=R2R, 1=M2R (load), 2=R2M (store), 3=treated as R2R.
REQ-006 mem_access_size  input  3  0=BYTE, 1=HALF, 2=WORD, 3=LEFT_WORD, 4=RIGHT_WORD, others=WORD.
REQ-007 mem_signed  input  1  1=sign-extend byte/half loads (LB/LH), 0=zero-extend (LBU/LHU).
REQ-008 mem_access_addr  input  32  byte address from ex.
REQ-009 val_input  input  32  ex result (R2R), store data (R2M), or old rt value for LWL/LWR merge.
REQ-010 bypass_reg_addr  input  5  destination register.
REQ-011 bus_req / bus_we  output  1 / 1  request strobe / write enable.
REQ-012 bus_addr  output  32  {mem_access_addr[31:2],2'b00}.
REQ-013 bus_byte_en / bus_wdata  output  4 / 32  lane enables, bit i = bits [8i+7:8i]; aligned store data.
REQ-014 bus_rdata / bus_ack  input  32 / 1  read word; completion, sampled only in ACCESS.
REQ-015 stall  output  1  combinational; 1 whenever state is ACCESS; upstream holds inputs.
REQ-016 out_valid / val_output / reg_addr_out  output  1 / 32 / 5  registered writeback result.
REQ-017 address_error / bus_error / bad_vaddr  output  1 / 1 / 32  one-cycle error pulses; faulting address.

Function
REQ-018 States IDLE and ACCESS only; inputs are captured only in IDLE.
REQ-019 IDLE, in_valid, R2R: next cycle out_valid=1, val_output=val_input, reg_addr_out=bypass_reg_addr; stay IDLE.
REQ-020 IDLE, in_valid, load/store, misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0): no bus request; next cycle address_error=1, bad_vaddr=addr, out_valid=1, reg_addr_out=0.
REQ-021 LEFT/RIGHT_WORD are never misaligned.
REQ-022 IDLE, in_valid, aligned load/store: enter ACCESS next cycle with bus_req=1, bus_addr, bus_we (1 for store), bus_byte_en and bus_wdata registered; held constant until exit.
REQ-023 Store lanes, k=addr[1:0]: BYTE en=1<<k, data=val_input<<8k; HALF en=3<<k, data=val_input<<8k; WORD en=4'hF, data=val_input; SWL en bits 0..k, data=val_input>>8(3-k); SWR en bits k..3, data=val_input<<8k.
REQ-024 Loads drive bus_byte_en=4'hF, bus_wdata=0.
REQ-025 ACCESS with bus_ack=1: bus_req=0 next cycle, state IDLE, out_valid=1; load returns formatted data with captured register; store returns reg_addr_out=0, val_output=0.
REQ-026 Load format, m=bus_rdata, r=captured val_input, k=addr[1:0]: BYTE m[8k+7:8k] extended; HALF m[8k+15:8k] extended; WORD m.
REQ-027 LWL: k=0 {m[7:0],r[23:0]}, k=1 {m[15:0],r[15:0]}, k=2 {m[23:0],r[7:0]}, k=3 m.
REQ-028 LWR: k=0 m, k=1 {r[31:24],m[31:8]}, k=2 {r[31:16],m[31:16]}, k=3 {r[31:8],m[31:24]}.
REQ-029 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ack; at BUS_TIMEOUT, next cycle: bus_req=0, IDLE, bus_error=1, bad_vaddr=addr, out_valid=1, reg_addr_out=0.
REQ-030 bus_ack in the same cycle the counter reaches BUS_TIMEOUT: ack wins, no bus_error.
REQ-031 out_valid, address_error, bus_error are single-cycle pulses; val_output, reg_addr_out, bad_vaddr hold until next update.
REQ-032 in_valid=0 in IDLE: out_valid=0 next cycle, no bus activity.
REQ-033 Back-to-back accepted accesses: completion cycle returns to IDLE; next instruction captured in the first IDLE cycle; minimum memory latency 2 cycles with same-cycle ack.

Reset
REQ-034 rst_n=0 at an edge: state IDLE, counter 0, all outputs 0 (stall=0), including mid-ACCESS (bus_req drops at that edge; the access is abandoned and no out_valid is produced).

Verification
REQ-035 R2R val_input=32'h1234_5678, reg 5 -> next cycle out_valid=1, val_output=32'h1234_5678, reg_addr_out=5, no bus_req.
REQ-036 LB signed addr=32'h0000_1003, bus_rdata=32'h80FF_0000, ack after 3 cycles -> bus_addr=32'h1000, stall 3 cycles, val_output=32'hFFFF_FF80.
REQ-037 SH addr=32'h0000_2002, val_input=32'h0000_ABCD -> bus_we=1, bus_byte_en=4'b1100, bus_wdata=32'hABCD_0000; completion reg_addr_out=0.
REQ-038 LWL k=1, r=32'h1122_3344, m=32'hAABB_CCDD -> val_output=32'hCCDD_3344; LWR k=2 same -> 32'h1122_AABB.
REQ-039 LW addr=32'h0000_0006 -> address_error pulse, bad_vaddr=32'h6, no bus_req; no ack for BUS_TIMEOUT cycles -> bus_error pulse, IDLE; rst_n=0 mid-ACCESS -> bus_req=0, stall=0 next edge.
